// File: rtl/line_seq_pkg.sv
// Shared definitions for the line sequencer: FSM state encoding, the ASCII
// bytes it emits on its own, and the parked memory address used while idle.
// Optional build macro LINE_SEQ_TERM_EN adds the CR/LF terminator states.
package line_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PTR_RD,
        ST_PTR_LD,
        ST_LHS_RD,
        ST_LHS_TX,
        ST_SEP_TX,
        ST_RHS_RD,
        ST_RHS_TX,
`ifdef LINE_SEQ_TERM_EN
        ST_TERM_CR,
        ST_TERM_LF,
`endif
        ST_FIN
    } seq_state_t;

    localparam logic [7:0] ASCII_EQ      = 8'h3D;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] IDLE_MEM_ADDR = 8'hFF;

endpackage

// File: rtl/line_sequencer.sv
// Line sequencer: looks up a line in the pointer table, then streams
// "lhs chars" '=' "rhs chars" from the character-pair memory over a
// valid/ready byte interface.
// Build option LINE_SEQ_TERM_EN: append CR LF after the right-hand pass.
module line_sequencer
    import line_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  line,
    output logic [7:0]  ptr_addr,
    input  logic [15:0] ptr_dout,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    seq_state_t r_state;
    logic [7:0] r_base;
    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic [7:0] r_ptr_addr;
    logic [7:0] r_mem_addr;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_last;
    logic [7:0] w_next_addr;
    logic [7:0] w_tx_data;

    // The current entry is the last of its pass; the address adder wraps mod 256.
    assign w_last      = (r_idx == (r_len - 8'd1));
    assign w_next_addr = r_base + r_idx + 8'd1;

    // Character bytes come straight from the memory, whose address is held for
    // the whole TX state, so the byte stays stable while the sink stalls.
    always_comb begin
        w_tx_data = r_tx_data;
        if (r_state == ST_LHS_TX) begin
            w_tx_data = mem_dout[15:8];
        end else if (r_state == ST_RHS_TX) begin
            w_tx_data = mem_dout[7:0];
        end
    end

    // Sequencer FSM: pointer lookup, two character passes, separator and optional terminator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_base     <= 8'h00;
            r_len      <= 8'h00;
            r_idx      <= 8'h00;
            r_ptr_addr <= 8'h00;
            r_mem_addr <= IDLE_MEM_ADDR;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr_addr <= line;
                        r_busy     <= 1'b1;
                        r_state    <= ST_PTR_RD;
                    end
                end
                ST_PTR_RD: begin
                    r_state <= ST_PTR_LD;
                end
                ST_PTR_LD: begin
                    r_base     <= ptr_dout[7:0];
                    r_len      <= ptr_dout[15:8];
                    r_idx      <= 8'h00;
                    r_ptr_addr <= 8'h00;
                    if (ptr_dout[15:8] == 8'h00) begin
                        r_tx_data  <= ASCII_EQ;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEP_TX;
                    end else begin
                        r_mem_addr <= ptr_dout[7:0];
                        r_state    <= ST_LHS_RD;
                    end
                end
                ST_LHS_RD: begin
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_LHS_TX;
                end
                ST_LHS_TX: begin
                    if (tx_ready) begin
                        if (w_last) begin
                            r_idx     <= 8'h00;
                            r_tx_data <= ASCII_EQ;
                            r_state   <= ST_SEP_TX;
                        end else begin
                            r_idx      <= r_idx + 8'd1;
                            r_mem_addr <= w_next_addr;
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_LHS_RD;
                        end
                    end
                end
                ST_SEP_TX: begin
                    if (tx_ready) begin
                        if (r_len == 8'h00) begin
`ifdef LINE_SEQ_TERM_EN
                            r_tx_data <= ASCII_CR;
                            r_state   <= ST_TERM_CR;
`else
                            r_tx_data  <= 8'h00;
                            r_tx_valid <= 1'b0;
                            r_mem_addr <= IDLE_MEM_ADDR;
                            r_done     <= 1'b1;
                            r_state    <= ST_FIN;
`endif
                        end else begin
                            r_mem_addr <= r_base;
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_RHS_RD;
                        end
                    end
                end
                ST_RHS_RD: begin
                    r_tx_valid <= 1'b1;
                    r_state    <= ST_RHS_TX;
                end
                ST_RHS_TX: begin
                    if (tx_ready) begin
                        if (w_last) begin
                            r_idx <= 8'h00;
`ifdef LINE_SEQ_TERM_EN
                            r_tx_data <= ASCII_CR;
                            r_state   <= ST_TERM_CR;
`else
                            r_tx_data  <= 8'h00;
                            r_tx_valid <= 1'b0;
                            r_mem_addr <= IDLE_MEM_ADDR;
                            r_done     <= 1'b1;
                            r_state    <= ST_FIN;
`endif
                        end else begin
                            r_idx      <= r_idx + 8'd1;
                            r_mem_addr <= w_next_addr;
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_RHS_RD;
                        end
                    end
                end
`ifdef LINE_SEQ_TERM_EN
                ST_TERM_CR: begin
                    if (tx_ready) begin
                        r_tx_data <= ASCII_LF;
                        r_state   <= ST_TERM_LF;
                    end
                end
                ST_TERM_LF: begin
                    if (tx_ready) begin
                        r_tx_data  <= 8'h00;
                        r_tx_valid <= 1'b0;
                        r_mem_addr <= IDLE_MEM_ADDR;
                        r_done     <= 1'b1;
                        r_state    <= ST_FIN;
                    end
                end
`endif
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_mem_addr <= IDLE_MEM_ADDR;
                    r_ptr_addr <= 8'h00;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ptr_addr = r_ptr_addr;
    assign mem_addr = r_mem_addr;
    assign tx_data  = w_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
